i2c_cfg_seq: RTL and testbench

- Register-init sequencer that sits directly upstream of the two-byte I2C master in the system block.
- Walks an external configuration table of {register, value} pairs, e.g. HDMI transmitter or audio codec setup.
- Issues one two-byte I2C write per entry. Handles delay and terminator entries.
- Retries NACKed writes, applies a transaction timeout, and reports DONE/ERROR status to the system.

---
 rtl/i2c_cfg_seq_if.sv | 22 ++
 rtl/i2c_cfg_seq.sv | 190 +++++++++++++++++++
 tb/tb_i2c_cfg_seq.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_cfg_seq_if.sv
// Signal bundle between the register-init sequencer and the two-byte I2C write master.
// The master modport is the sequencer side and the slave modport is the I2C master side.
interface i2c_cfg_seq_if;
  logic       i2c_start;
  logic       i2c_read;
  logic [6:0] i2c_addr;
  logic       i2c_wlen;
  logic [7:0] i2c_wdata1;
  logic [7:0] i2c_wdata2;
  logic       i2c_end;
  logic       i2c_ack;

  modport master (
    output i2c_start, i2c_read, i2c_addr, i2c_wlen, i2c_wdata1, i2c_wdata2,
    input  i2c_end, i2c_ack
  );

  modport slave (
    input  i2c_start, i2c_read, i2c_addr, i2c_wlen, i2c_wdata1, i2c_wdata2,
    output i2c_end, i2c_ack
  );
endinterface

// File: rtl/i2c_cfg_seq.sv
// Walks a {register, value} table and issues one two-byte I2C write per entry.
// Supports delay and terminator entries, NACK retries and a transfer timeout.
module i2c_cfg_seq #(
  parameter logic [6:0] DEV_ADDR   = 7'h39,
  parameter int         TBL_AW     = 6,
  parameter int         RETRY_MAX  = 3,
  parameter int         TIMEOUT    = 200000,
  parameter int         DELAY_UNIT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  output logic [TBL_AW-1:0] tbl_addr,
  input  logic [15:0]       tbl_data,
  i2c_cfg_seq_if.master     i2c,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [TBL_AW-1:0] fail_idx
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT, S_DRAIN,
    S_CHECK, S_DELAY, S_NEXT, S_DONE, S_FAIL
  } state_t;

  localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

  state_t      state;
  logic        old_go;
  logic        go_pend;
  logic        start;
  logic [7:0]  wdata1;
  logic [7:0]  wdata2;
  logic [7:0]  retry;
  logic [31:0] tcnt;
  logic [31:0] dcnt;
  logic        timed_out;

  logic go_edge;
  logic in_xfer;
  logic restart;

  assign go_edge = go & ~old_go;
  assign in_xfer = (state == S_ISSUE) || (state == S_WAIT) || (state == S_DRAIN);
  assign restart = (go_edge | go_pend) & ~in_xfer;

  assign i2c.i2c_start  = start;
  assign i2c.i2c_read   = 1'b0;
  assign i2c.i2c_addr   = DEV_ADDR;
  assign i2c.i2c_wlen   = 1'b1;
  assign i2c.i2c_wdata1 = wdata1;
  assign i2c.i2c_wdata2 = wdata2;

  // Sequencer FSM; a GO edge seen mid-transfer is parked in go_pend until the master is idle again.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      old_go    <= 1'b0;
      go_pend   <= 1'b0;
      start     <= 1'b0;
      wdata1    <= 8'h00;
      wdata2    <= 8'h00;
      retry     <= 8'h00;
      tcnt      <= 32'd0;
      dcnt      <= 32'd0;
      timed_out <= 1'b0;
      tbl_addr  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      fail_idx  <= '0;
    end else begin
      old_go <= go;
      if (go_edge && in_xfer) begin
        go_pend <= 1'b1;
      end
      if (restart) begin
        go_pend  <= 1'b0;
        tbl_addr <= '0;
        retry    <= 8'h00;
        done     <= 1'b0;
        error    <= 1'b0;
        busy     <= 1'b1;
        state    <= S_FETCH;
      end else begin
        case (state)
          S_IDLE: begin
            busy <= 1'b0;
          end
          S_FETCH: begin
            state <= S_DECODE;
          end
          S_DECODE: begin
            if (tbl_data == 16'hFFFF) begin
              state <= S_DONE;
            end else if (tbl_data[15:8] == 8'hFE) begin
              dcnt  <= 32'(tbl_data[7:0]) * 32'(DELAY_UNIT);
              state <= (tbl_data[7:0] == 8'h00) ? S_NEXT : S_DELAY;
            end else begin
              wdata1    <= tbl_data[15:8];
              wdata2    <= tbl_data[7:0];
              tcnt      <= 32'd0;
              timed_out <= 1'b0;
              state     <= S_ISSUE;
            end
          end
          S_ISSUE: begin
            tcnt <= tcnt + 32'd1;
            if (tcnt == TO_LAST) begin
              start     <= 1'b0;
              timed_out <= 1'b1;
              tcnt      <= 32'd0;
              state     <= i2c.i2c_end ? S_CHECK : S_DRAIN;
            end else if (!start) begin
              // START was low last cycle; only raise it once the master reports idle.
              start <= i2c.i2c_end;
            end else if (!i2c.i2c_end) begin
              start <= 1'b0;
              state <= S_WAIT;
            end
          end
          S_WAIT: begin
            tcnt <= tcnt + 32'd1;
            if (i2c.i2c_end) begin
              state <= S_CHECK;
            end else if (tcnt == TO_LAST) begin
              timed_out <= 1'b1;
              tcnt      <= 32'd0;
              state     <= S_DRAIN;
            end
          end
          S_DRAIN: begin
            tcnt <= tcnt + 32'd1;
            if (i2c.i2c_end) begin
              state <= S_CHECK;
            end else if (tcnt == TO_LAST) begin
              state <= S_FAIL;
            end
          end
          S_CHECK: begin
            if (!i2c.i2c_ack && !timed_out) begin
              retry <= 8'h00;
              state <= S_NEXT;
            end else if (retry < 8'(RETRY_MAX)) begin
              retry     <= retry + 8'h01;
              tcnt      <= 32'd0;
              timed_out <= 1'b0;
              state     <= S_ISSUE;
            end else begin
              state <= S_FAIL;
            end
          end
          S_DELAY: begin
            if (dcnt == 32'd0) begin
              state <= S_NEXT;
            end else begin
              dcnt <= dcnt - 32'd1;
            end
          end
          S_NEXT: begin
            if (&tbl_addr) begin
              state <= S_DONE;
            end else begin
              tbl_addr <= tbl_addr + TBL_AW'(1);
              state    <= S_FETCH;
            end
          end
          S_DONE: begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          S_FAIL: begin
            error    <= 1'b1;
            fail_idx <= tbl_addr;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end
          default: begin
            start <= 1'b0;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_cfg_seq.sv
// Directed bench for i2c_cfg_seq: table-driven sequence runs against a behavioural
// I2C master and sync ROM, plus hand-written reset and GO-during-transfer sequences.
module tb_i2c_cfg_seq;
  localparam int TBL_AW = 6;

  logic              clk      = 1'b0;
  logic              reset    = 1'b1;
  logic              go       = 1'b0;
  logic [TBL_AW-1:0] tbl_addr;
  logic [15:0]       tbl_data = 16'h0000;
  logic              busy;
  logic              done;
  logic              error;
  logic [TBL_AW-1:0] fail_idx;

  i2c_cfg_seq_if bus();

  i2c_cfg_seq #(
    .DEV_ADDR(7'h39), .TBL_AW(TBL_AW), .RETRY_MAX(3), .TIMEOUT(1000), .DELAY_UNIT(1024)
  ) dut (
    .clk(clk), .reset(reset), .go(go), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .i2c(bus), .busy(busy), .done(done), .error(error), .fail_idx(fail_idx)
  );

  always #5 clk = ~clk;

  logic [15:0] rom [64];
  always @(posedge clk) tbl_data <= rom[tbl_addr];

  // Behavioural master: accepts on a START rising edge, busy for 5 cycles, NACK per config.
  logic        m_end     = 1'b1;
  logic        m_ack     = 1'b0;
  logic        m_busy    = 1'b0;
  logic        m_nack    = 1'b0;
  logic        start_d   = 1'b0;
  logic        m_clr     = 1'b0;
  logic        stuck     = 1'b0;
  logic [7:0]  nack_reg  = 8'h00;
  int          nack_cnt  = 0;
  int          nack_seen = 0;
  int          m_cnt     = 0;
  int          cyc       = 0;
  logic [15:0] xq[$];
  int          sq[$];

  assign bus.i2c_end = m_end;
  assign bus.i2c_ack = m_ack;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    start_d <= bus.i2c_start;
    if (m_clr) begin
      xq.delete();
      sq.delete();
      nack_seen <= 0;
    end else if (bus.i2c_start && !start_d) begin
      sq.push_back(cyc);
    end
    if (!m_busy) begin
      if (bus.i2c_start && !start_d && !stuck && !m_clr) begin
        m_busy <= 1'b1;
        m_end  <= 1'b0;
        m_cnt  <= 4;
        xq.push_back({bus.i2c_wdata1, bus.i2c_wdata2});
        if (bus.i2c_wdata1 == nack_reg && nack_seen < nack_cnt) begin
          m_nack    <= 1'b1;
          nack_seen <= nack_seen + 1;
        end else begin
          m_nack <= 1'b0;
        end
      end
    end else if (m_cnt == 0) begin
      m_busy <= 1'b0;
      m_end  <= 1'b1;
      m_ack  <= m_nack;
    end else begin
      m_cnt <= m_cnt - 1;
    end
  end

  typedef struct {
    logic [3:0][15:0] tbl;
    logic [7:0]       nreg;
    int               ncnt;
    logic             stk;
    logic             edone;
    logic             eerr;
    int               efidx;
    int               estarts;
    int               enacc;
    logic [15:0]      ex0;
    logic [15:0]      ex1;
    int               lmin;
    int               lmax;
  } vec_t;

  vec_t vecs[5];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mkvec(input logic [15:0] e0, e1, e2, e3, input logic [7:0] nreg,
                                 input int ncnt, input logic stk, edone, eerr,
                                 input int efidx, estarts, enacc,
                                 input logic [15:0] ex0, ex1, input int lmin, lmax);
    vec_t v;
    v.tbl[0] = e0; v.tbl[1] = e1; v.tbl[2] = e2; v.tbl[3] = e3;
    v.nreg = nreg; v.ncnt = ncnt; v.stk = stk; v.edone = edone; v.eerr = eerr;
    v.efidx = efidx; v.estarts = estarts; v.enacc = enacc; v.ex0 = ex0; v.ex1 = ex1;
    v.lmin = lmin; v.lmax = lmax;
    return v;
  endfunction

  function automatic logic [15:0] xget(input int i);
    if (i < xq.size()) return xq[i];
    else return 16'hDEAD;
  endfunction

  task automatic load_tbl(input logic [3:0][15:0] t);
    for (int i = 0; i < 64; i++) rom[i] = 16'hFFFF;
    for (int i = 0; i < 4; i++) rom[i] = t[i];
  endtask

  task automatic clear_master();
    @(negedge clk); m_clr = 1'b1;
    @(negedge clk); m_clr = 1'b0;
  endtask

  task automatic pulse_go(output int gcyc);
    @(negedge clk); go = 1'b1; gcyc = cyc;
    @(negedge clk); go = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(n < 20000), 32'd1);
  endtask

  task automatic wait_xq(input int cnt, input string nm);
    int n = 0;
    while (xq.size() < cnt && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(n < 2000), 32'd1);
  endtask

  initial begin
    int gcyc;
    int lat;
    for (int i = 0; i < 64; i++) rom[i] = 16'hFFFF;
    repeat (3) @(negedge clk);
    chk("rst_busy",   32'(busy), 32'd0);
    chk("rst_done",   32'(done), 32'd0);
    chk("rst_error",  32'(error), 32'd0);
    chk("rst_start",  32'(bus.i2c_start), 32'd0);
    chk("rst_addr",   32'(tbl_addr), 32'd0);
    chk("rst_fidx",   32'(fail_idx), 32'd0);
    chk("rst_wdata",  32'({bus.i2c_wdata1, bus.i2c_wdata2}), 32'd0);
    chk("const_bus",  32'({bus.i2c_read, bus.i2c_wlen, bus.i2c_addr}), 32'h0B9);
    reset = 1'b0;

    vecs[0] = mkvec(16'h1041, 16'h9803, 16'hFFFF, 16'hFFFF, 8'h00, 0, 1'b0,
                    1'b1, 1'b0, 0, 2, 2, 16'h1041, 16'h9803, 0, 10);
    vecs[1] = mkvec(16'h1041, 16'h9803, 16'h2277, 16'hFFFF, 8'h22, 2, 1'b0,
                    1'b1, 1'b0, 0, 5, 5, 16'h1041, 16'h9803, 0, 10);
    vecs[2] = mkvec(16'h1041, 16'h9803, 16'h2277, 16'hFFFF, 8'h98, 255, 1'b0,
                    1'b0, 1'b1, 1, 5, 5, 16'h1041, 16'h9803, 0, 10);
    vecs[3] = mkvec(16'hFE02, 16'h2055, 16'hFFFF, 16'hFFFF, 8'h00, 0, 1'b0,
                    1'b1, 1'b0, 0, 1, 1, 16'h2055, 16'h0000, 2050, 2070);
    vecs[4] = mkvec(16'h1041, 16'hFFFF, 16'hFFFF, 16'hFFFF, 8'h00, 0, 1'b1,
                    1'b0, 1'b1, 0, 4, 0, 16'h0000, 16'h0000, 0, 10);

    for (int v = 0; v < 5; v++) begin
      load_tbl(vecs[v].tbl);
      stuck    = vecs[v].stk;
      nack_reg = vecs[v].nreg;
      nack_cnt = vecs[v].ncnt;
      clear_master();
      pulse_go(gcyc);
      chk($sformatf("v%0d_busy_up", v), 32'(busy), 32'd1);
      wait_idle($sformatf("v%0d_idle_bound", v));
      repeat (20) @(negedge clk);
      chk($sformatf("v%0d_done", v), 32'(done), 32'(vecs[v].edone));
      chk($sformatf("v%0d_error", v), 32'(error), 32'(vecs[v].eerr));
      if (vecs[v].eerr) chk($sformatf("v%0d_fidx", v), 32'(fail_idx), 32'(vecs[v].efidx));
      chk($sformatf("v%0d_starts", v), 32'(sq.size()), 32'(vecs[v].estarts));
      chk($sformatf("v%0d_accepted", v), 32'(xq.size()), 32'(vecs[v].enacc));
      if (vecs[v].enacc >= 1) chk($sformatf("v%0d_x0", v), 32'(xget(0)), 32'(vecs[v].ex0));
      if (vecs[v].enacc >= 2) chk($sformatf("v%0d_x1", v), 32'(xget(1)), 32'(vecs[v].ex1));
      lat = (sq.size() > 0) ? sq[0] - gcyc : -1;
      chk($sformatf("v%0d_first_start_lat", v),
          32'(lat >= vecs[v].lmin && lat <= vecs[v].lmax), 32'd1);
      if (vecs[v].stk && sq.size() >= 2) begin
        lat = sq[1] - sq[0];
        chk("stuck_attempt_len", 32'(lat >= 1000 && lat <= 1010), 32'd1);
      end
    end

    // Reset while entry 1 is in flight.
    stuck = 1'b0; nack_cnt = 0;
    load_tbl({16'hFFFF, 16'hFFFF, 16'h9803, 16'h1041});
    clear_master();
    pulse_go(gcyc);
    wait_xq(2, "rst_mid_reach");
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_busy",  32'(busy), 32'd0);
    chk("rst_mid_done",  32'(done), 32'd0);
    chk("rst_mid_error", 32'(error), 32'd0);
    chk("rst_mid_start", 32'(bus.i2c_start), 32'd0);
    chk("rst_mid_addr",  32'(tbl_addr), 32'd0);
    reset = 1'b0;
    repeat (20) @(negedge clk);

    // GO during entry 0 transfer: transfer completes, then restart from entry 0.
    clear_master();
    pulse_go(gcyc);
    wait_xq(1, "go_mid_reach");
    pulse_go(gcyc);
    wait_idle("go_mid_idle_bound");
    repeat (20) @(negedge clk);
    chk("go_mid_accepted", 32'(xq.size()), 32'd3);
    chk("go_mid_x0", 32'(xget(0)), 32'h1041);
    chk("go_mid_x1", 32'(xget(1)), 32'h1041);
    chk("go_mid_x2", 32'(xget(2)), 32'h9803);
    chk("go_mid_done", 32'(done), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
